// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Frame: start(0), DATA_W data bits LSB first, optional parity, stop(1).
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: oversampling counter, bit counter and the
// three-point majority vote taken around the middle of each bit cell.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active,
    input  logic       restart,
    input  logic       rx_s,
    output logic       sample_bit,
    output logic       sample_vld,
    output logic       bit_done,
    output logic [3:0] bit_cnt
);

    localparam int unsigned CntW = $clog2(PRESCALE);

    localparam logic [CntW-1:0] MidLo = CntW'(PRESCALE / 2 - 1);
    localparam logic [CntW-1:0] Mid   = CntW'(PRESCALE / 2);
    localparam logic [CntW-1:0] MidHi = CntW'(PRESCALE / 2 + 1);
    localparam logic [CntW-1:0] Last  = CntW'(PRESCALE - 1);

    logic [CntW-1:0] edge_cnt;
    logic            s0;
    logic            s1;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
        end else if (active) begin
            if (edge_cnt == Last) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (edge_cnt == MidLo) begin
                s0 <= rx_s;
            end
            if (edge_cnt == Mid) begin
                s1 <= rx_s;
            end
        end
    end

    // Third sample is the live synchronised line; the FSM registers the vote.
    always_comb begin
        sample_bit = majority3(s0, s1, rx_s);
        sample_vld = active && (edge_cnt == MidHi);
        bit_done   = active && (edge_cnt == Last);
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises RX_IN, deserialises an LSB-first frame, checks
// parity and stop bit, and emits the byte with one-cycle status pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic [DATA_W-1:0] P_DATA,
    output logic              DATA_VALID,
    output logic              PAR_ERR,
    output logic              STP_ERR
);

    rx_state_t         state;
    logic              rx_meta;
    logic              rx_s;
    logic [DATA_W-1:0] shift;
    logic              rx_par;
    logic              par_en_q;
    logic              par_typ_q;

    logic              active;
    logic              restart;
    logic              sample_bit;
    logic              sample_vld;
    logic              bit_done;
    logic [3:0]        bit_cnt;
    logic              par_calc;
    logic              par_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        active   = (state != StIdle);
        restart  = (state == StIdle) && !rx_s;
        par_calc = (par_typ_q == PAR_ODD) ? ~(^shift) : ^shift;
        par_err  = par_en_q && (rx_par != par_calc);
    end

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .clk        (CLK),
        .rst        (RST),
        .active     (active),
        .restart    (restart),
        .rx_s       (rx_s),
        .sample_bit (sample_bit),
        .sample_vld (sample_vld),
        .bit_done   (bit_done),
        .bit_cnt    (bit_cnt)
    );

    // bit_cnt is 0 for the start bit, so data bit 7 ends with bit_cnt == DATA_W.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= StIdle;
            shift      <= '0;
            rx_par     <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state     <= StStart;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                    end
                end
                StStart: begin
                    if (sample_vld && sample_bit) begin
                        state <= StIdle;
                    end else if (bit_done) begin
                        state <= StData;
                    end
                end
                StData: begin
                    if (sample_vld) begin
                        shift <= {sample_bit, shift[DATA_W-1:1]};
                    end
                    if (bit_done && (bit_cnt == 4'(DATA_W))) begin
                        state <= par_en_q ? StParity : StStop;
                    end
                end
                StParity: begin
                    if (sample_vld) begin
                        rx_par <= sample_bit;
                    end
                    if (bit_done) begin
                        state <= StStop;
                    end
                end
                StStop: begin
                    // Re-arm at mid-stop so a back-to-back start bit is not missed.
                    if (sample_vld) begin
                        state   <= StIdle;
                        PAR_ERR <= par_err;
                        STP_ERR <= ~sample_bit;
                        if (!par_err && sample_bit) begin
                            P_DATA     <= shift;
                            DATA_VALID <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: frames are built from the line
// protocol and compared against an event scoreboard with timing windows.
module tb_uart_rx;

    localparam int unsigned P = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    uart_rx #(
        .PRESCALE (P)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        dv;
        logic        pe;
        logic        se;
        logic [7:0]  data;
    } obs_t;

    typedef struct {
        logic        dv;
        logic        pe;
        logic        se;
        logic [7:0]  data;
        int unsigned lo;
        int unsigned hi;
    } exp_t;

    obs_t        obs_q[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  model_pdata;
    int unsigned prev_cyc;
    int unsigned last_cyc;

    always @(negedge CLK) begin
        if (DATA_VALID || PAR_ERR || STP_ERR) begin
            obs_t o;
            o.cyc  = cyc;
            o.dv   = DATA_VALID;
            o.pe   = PAR_ERR;
            o.se   = STP_ERR;
            o.data = P_DATA;
            obs_q.push_back(o);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called one step after a rising edge; leaves the bench at the same phase.
    task automatic drive_bit(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic bad_par, input logic stop_v, input int corrupt);
        int unsigned k;
        int          ones;
        logic        pbit;
        logic        perr;
        logic        serr;
        exp_t        e;
        ones = $countones(d);
        // Parity bit that makes the total count of ones even (or odd).
        pbit = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
        if (bad_par) pbit = ~pbit;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        k = cyc;
        drive_bit(1'b0, P);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            if (i == corrupt) begin
                drive_bit(d[i], 4);
                drive_bit(~d[i], 1);
                drive_bit(d[i], P - 5);
            end else begin
                drive_bit(d[i], P);
            end
        end
        if (pen) drive_bit(pbit, P);
        drive_bit(stop_v, P);
        perr   = pen && bad_par;
        serr   = !stop_v;
        e.dv   = !perr && !serr;
        e.pe   = perr;
        e.se   = serr;
        e.data = e.dv ? d : model_pdata;
        e.lo   = k + P * (9 + int'(pen)) + 4;
        e.hi   = e.lo + 10;
        if (e.dv) model_pdata = d;
        exp_q.push_back(e);
        if (!stop_v) drive_bit(1'b1, 12);
    endtask

    task automatic check_events(input string tag);
        obs_t o;
        exp_t e;
        repeat (16) @(posedge CLK);
        #1;
        check_eq($sformatf("%s.count", tag), obs_q.size(), exp_q.size());
        prev_cyc = 0;
        last_cyc = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            prev_cyc = last_cyc;
            last_cyc = o.cyc;
            check_eq($sformatf("%s.valid", tag), o.dv, e.dv);
            check_eq($sformatf("%s.par_err", tag), o.pe, e.pe);
            check_eq($sformatf("%s.stp_err", tag), o.se, e.se);
            check_eq($sformatf("%s.data", tag), o.data, e.data);
            check_eq($sformatf("%s.timing", tag), (o.cyc >= e.lo) && (o.cyc <= e.hi), 1);
        end
        obs_q.delete();
        exp_q.delete();
        check_eq($sformatf("%s.p_data_hold", tag), P_DATA, model_pdata);
    endtask

    initial begin
        RST     = 1'b1;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        model_pdata = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        drive_bit(1'b1, 4);
        check_eq("reset.p_data", P_DATA, 8'h00);
        check_eq("reset.pulses", {DATA_VALID, PAR_ERR, STP_ERR}, 3'b000);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        check_events("t1_even_par");

        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        check_events("t2_bad_par");

        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_events("t3_bad_stop");

        drive_bit(1'b0, 2);
        drive_bit(1'b1, 20);
        check_events("t4_glitch");
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        check_events("t4_after_glitch");

        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        check_events("t5_b2b");
        check_eq("t5.spacing", last_cyc - prev_cyc, 80);

        PAR_EN = 1'b0;
        drive_bit(1'b0, P);
        for (int i = 0; i < 4; i++) drive_bit(1'($urandom), P);
        drive_bit(1'b1, 4);
        RST = 1'b1;
        drive_bit(1'b1, 2);
        RST = 1'b0;
        model_pdata = 8'h00;
        drive_bit(1'b1, 10);
        check_events("t6_abort");
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        check_events("t6_after_reset");

        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        check_events("t7_vote");

        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       pen;
            logic       ptyp;
            logic       bad;
            logic       stp;
            int         corrupt;
            d       = 8'($urandom);
            pen     = 1'($urandom);
            ptyp    = 1'($urandom);
            bad     = pen && ($urandom_range(0, 3) == 0);
            stp     = ($urandom_range(0, 5) != 0);
            corrupt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            drive_bit(1'b1, $urandom_range(0, 6));
            send_frame(d, pen, ptyp, bad, stp, corrupt);
        end
        check_events("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
